clkgate_ctrl: RTL and testbench

Run/halt/step sequencer that drives the `en` input of `edgegate` and so decides which CPU clock pulses reach the core. It accepts debug commands (halt, free-run, step N cycles) and an external halt request from the core (HLT instruction or breakpoint). It produces a registered enable that changes only on the rising edge of `clk`, so the downstream gate never sees `en` move during a high phase.

---
 rtl/clkgate_ctrl.sv | 147 ++++++++++++++
 tb/tb_clkgate_ctrl.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/clkgate_ctrl.sv
// clkgate_ctrl: run/halt/step sequencer that drives edgegate.en.
// The enable is a flop that only changes on the rising edge of clk, so the
// downstream gate never sees it move during a high phase.
//
// Command handshake: cmd_ready is tied high, so a command is taken on every
// rising edge where cmd_valid is 1; there is no back-pressure.
module clkgate_ctrl #(
  parameter int CW = 16,
  parameter int PW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [1:0]    cmd_op,
  input  logic [CW-1:0] cmd_count,
  input  logic          halt_req,
  output logic          gate_en,
  output logic          running,
  output logic [CW-1:0] remaining,
  output logic [PW-1:0] pulse_count,
  output logic          done,
  output logic          abort,
  output logic          cmd_err,
  output logic [1:0]    dbg_state
);

  typedef enum logic [1:0] {
    ST_HALTED = 2'd0,
    ST_RUN    = 2'd1,
    ST_BURST  = 2'd2
  } state_e;

  localparam logic [1:0] OP_HALT   = 2'b00;
  localparam logic [1:0] OP_RUN    = 2'b01;
  localparam logic [1:0] OP_STEP   = 2'b10;
  localparam logic [1:0] OP_CLRCNT = 2'b11;

  state_e        state_q, state_d;
  logic          gate_en_q, gate_en_d;
  logic [CW-1:0] remaining_q, remaining_d;
  logic [PW-1:0] pulse_count_q, pulse_count_d;
  logic          done_q, done_d;
  logic          abort_q, abort_d;
  logic          cmd_err_q, cmd_err_d;

  logic is_run, is_step, is_halt, is_clr, stop_req;

  assign is_run   = cmd_valid && (cmd_op == OP_RUN);
  assign is_step  = cmd_valid && (cmd_op == OP_STEP);
  assign is_halt  = cmd_valid && (cmd_op == OP_HALT);
  assign is_clr   = cmd_valid && (cmd_op == OP_CLRCNT);
  // A halt from either source outranks completion and new commands.
  assign stop_req = halt_req || is_halt;

  // Next-state, remaining count and event pulses.
  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    done_d      = 1'b0;
    abort_d     = 1'b0;
    cmd_err_d   = 1'b0;
    unique case (state_q)
      ST_HALTED: begin
        if (is_run || is_step) begin
          if (halt_req) begin
            cmd_err_d = 1'b1;
          end else if (is_run) begin
            state_d = ST_RUN;
          end else if (cmd_count == '0) begin
            remaining_d = '0;
            done_d      = 1'b1;
          end else begin
            state_d     = ST_BURST;
            remaining_d = cmd_count;
          end
        end
      end
      ST_RUN: begin
        if (stop_req) begin
          state_d = ST_HALTED;
          abort_d = 1'b1;
        end else if (is_run || is_step) begin
          cmd_err_d = 1'b1;
        end
      end
      ST_BURST: begin
        if (stop_req) begin
          // Keep the un-executed count; this cycle's decrement is dropped.
          state_d = ST_HALTED;
          abort_d = 1'b1;
        end else begin
          cmd_err_d = is_run || is_step;
          if (remaining_q == CW'(1)) begin
            state_d     = ST_HALTED;
            remaining_d = '0;
            done_d      = 1'b1;
          end else begin
            remaining_d = remaining_q - CW'(1);
          end
        end
      end
      default: begin
        state_d = ST_HALTED;
      end
    endcase
    gate_en_d = (state_d != ST_HALTED);
  end

  // Pulse counter: counts cycles with the enable high; CLRCNT wins.
  always_comb begin
    pulse_count_d = pulse_count_q + PW'(gate_en_q);
    if (is_clr) pulse_count_d = '0;
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_HALTED;
      gate_en_q     <= 1'b0;
      remaining_q   <= '0;
      pulse_count_q <= '0;
      done_q        <= 1'b0;
      abort_q       <= 1'b0;
      cmd_err_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      gate_en_q     <= gate_en_d;
      remaining_q   <= remaining_d;
      pulse_count_q <= pulse_count_d;
      done_q        <= done_d;
      abort_q       <= abort_d;
      cmd_err_q     <= cmd_err_d;
    end
  end

  assign cmd_ready   = 1'b1;
  assign gate_en     = gate_en_q;
  assign running     = gate_en_q;
  assign remaining   = remaining_q;
  assign pulse_count = pulse_count_q;
  assign done        = done_q;
  assign abort       = abort_q;
  assign cmd_err     = cmd_err_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_clkgate_ctrl.sv
// Bench for clkgate_ctrl: directed scenarios followed by random commands,
// checked cycle by cycle against a behavioural model through an expected queue.
module tb_clkgate_ctrl;

  localparam int CW = 16;
  localparam int PW = 4;
  localparam int W  = 1 + 1 + CW + PW + 1 + 1 + 1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [1:0]    cmd_op;
  logic [CW-1:0] cmd_count;
  logic          halt_req;
  logic          gate_en;
  logic          running;
  logic [CW-1:0] remaining;
  logic [PW-1:0] pulse_count;
  logic          done;
  logic          abort;
  logic          cmd_err;
  logic [1:0]    dbg_state;

  clkgate_ctrl #(.CW(CW), .PW(PW)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_count(cmd_count),
    .halt_req(halt_req),
    .gate_en(gate_en), .running(running),
    .remaining(remaining), .pulse_count(pulse_count),
    .done(done), .abort(abort), .cmd_err(cmd_err),
    .dbg_state(dbg_state)
  );

  // ---------------- reference model ----------------
  // Behaviour is held as "free running" and "steps left in a burst" rather
  // than a state encoding; enabled = free running or a burst is in flight.
  bit m_free;
  bit m_burst;
  int m_left;     // remaining as observed
  int m_pulses;   // total enabled edges, kept modulo 2**PW
  bit m_done, m_abort, m_err;

  logic [W-1:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  function automatic logic [W-1:0] pack_exp();
    bit en;
    en = m_free || m_burst;
    return {en, en, CW'(m_left), PW'(m_pulses), m_done, m_abort, m_err};
  endfunction

  // Applies one edge of the model for the given inputs.
  task automatic model_edge(input bit v, input bit [1:0] op, input int n,
                            input bit h, input bit r);
    bit enabled_now, wants_go, halt_now;
    m_done = 0; m_abort = 0; m_err = 0;
    if (r) begin
      m_free = 0; m_burst = 0; m_left = 0; m_pulses = 0;
      return;
    end
    enabled_now = m_free || m_burst;
    wants_go    = v && (op == 2'b01 || op == 2'b10);
    halt_now    = h || (v && op == 2'b00);
    if (v && op == 2'b11) m_pulses = 0;
    else if (enabled_now) m_pulses = (m_pulses + 1) % (1 << PW);
    if (!enabled_now) begin
      if (wants_go && h) m_err = 1;
      else if (wants_go && op == 2'b01) m_free = 1;
      else if (wants_go && n == 0) begin m_left = 0; m_done = 1; end
      else if (wants_go) begin m_burst = 1; m_left = n; end
    end else if (halt_now) begin
      m_free = 0; m_burst = 0; m_abort = 1;
    end else begin
      m_err = wants_go;
      if (m_burst) begin
        m_left = m_left - 1;
        if (m_left == 0) begin m_burst = 0; m_done = 1; end
      end
    end
  endtask

  // ---------------- driver ----------------
  task automatic drive(input bit v, input bit [1:0] op, input int n,
                       input bit h, input bit r);
    rst       = r;
    cmd_valid = v;
    cmd_op    = op;
    cmd_count = CW'(n);
    halt_req  = h;
    model_edge(v, op, n, h, r);
    exp_q.push_back(pack_exp());
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int k);
    for (int i = 0; i < k; i++) drive(0, 2'b00, 0, 0, 0);
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    logic [W-1:0] exp_v, act_v;
    cyc++;
    if (exp_q.size() > 0) begin
      exp_v = exp_q.pop_front();
      act_v = {gate_en, running, remaining, pulse_count, done, abort, cmd_err};
      n_checks++;
      if (act_v !== exp_v) begin
        n_fail++;
        $display("FAIL outputs cyc %0d: got en=%b run=%b rem=%0d pc=%0d done=%b abort=%b err=%b, exp en=%b run=%b rem=%0d pc=%0d done=%b abort=%b err=%b",
                 cyc, act_v[W-1], act_v[W-2], act_v[W-3 -: CW], act_v[2+PW -: PW],
                 act_v[2], act_v[1], act_v[0],
                 exp_v[W-1], exp_v[W-2], exp_v[W-3 -: CW], exp_v[2+PW -: PW],
                 exp_v[2], exp_v[1], exp_v[0]);
      end
      n_checks++;
      if (cmd_ready !== 1'b1) begin
        n_fail++;
        $display("FAIL cmd_ready cyc %0d: got %b exp 1", cyc, cmd_ready);
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    rst = 1; cmd_valid = 0; cmd_op = 0; cmd_count = 0; halt_req = 0;
    drive(0, 0, 0, 0, 1);
    drive(0, 0, 0, 0, 1);
    idle(2);

    // Reset held two cycles in the middle of RUN.
    drive(1, 2'b01, 0, 0, 0);
    idle(3);
    drive(0, 0, 0, 0, 1);
    drive(0, 0, 0, 0, 1);
    idle(2);

    // STEP 3 from HALTED.
    drive(1, 2'b10, 3, 0, 0);
    idle(5);

    // STEP 0, RUN under halt_req, STEP during RUN.
    drive(1, 2'b10, 0, 0, 0);
    idle(2);
    drive(1, 2'b01, 0, 1, 0);
    idle(2);
    drive(1, 2'b01, 0, 0, 0);
    idle(1);
    drive(1, 2'b10, 5, 0, 0);
    idle(2);
    drive(1, 2'b00, 0, 0, 0);
    idle(2);

    // STEP 10, halt_req at the 4th enabled edge.
    drive(1, 2'b11, 0, 0, 0);
    drive(1, 2'b10, 10, 0, 0);
    idle(3);
    drive(0, 0, 0, 1, 0);
    idle(3);

    // HALT on the final edge of STEP 2.
    drive(1, 2'b10, 2, 0, 0);
    idle(1);
    drive(1, 2'b00, 0, 0, 0);
    idle(3);

    // Back-to-back STEP 2, second issued in the done cycle.
    drive(1, 2'b11, 0, 0, 0);
    drive(1, 2'b10, 2, 0, 0);
    idle(2);
    drive(1, 2'b10, 2, 0, 0);
    idle(4);

    // Counter wrap: RUN 18 cycles, then CLRCNT while running.
    drive(1, 2'b11, 0, 0, 0);
    drive(1, 2'b01, 0, 0, 0);
    idle(17);
    drive(1, 2'b11, 0, 0, 0);
    idle(3);
    drive(1, 2'b00, 0, 0, 0);
    idle(2);

    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      bit v, h, r;
      bit [1:0] op;
      int n;
      v  = ($urandom_range(0, 99) < 45);
      op = 2'($urandom_range(0, 3));
      n  = $urandom_range(0, 6);
      h  = ($urandom_range(0, 99) < 8);
      r  = ($urandom_range(0, 199) == 0);
      drive(v, op, n, h, r);
    end
    idle(2);

    // Bounded drain of the expected queue.
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    if (exp_q.size() > 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain: got %0d pending entries, exp 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
